// File: rtl/control_sequencer.sv
// control_sequencer: hardwired control unit for the datapath.
// Fetch (T0-T2) followed by execute (T3-T6) for reg-reg ALU, MUL/DIV and HALT.
// All strobes are Moore decodes of the registered state (plus IR select fields).
// Optional build macro SINGLE_STEP_EN: one instruction per rising edge of Run,
// returning to IDLE after every Done. Without it, Run is level-sensitive and
// instructions run back to back.
// Handshake: in T1, Read is asserted and held; the memory answers by raising
// Mem_ready for one cycle when Mdatain carries valid data. The transfer happens
// on the clock edge where Read=1 and Mem_ready=1; Mem_ready outside T1 is ignored.
module control_sequencer #(
  parameter int OPCODE_W     = 5,
  parameter int NREG         = 16,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic                Run,
  input  logic                Mem_ready,
  input  logic [31:0]         IR,
  output logic                PCout,
  output logic                ZLowout,
  output logic                ZHighout,
  output logic                MDRout,
  output logic                MARin,
  output logic                PCin,
  output logic                MDRin,
  output logic                IRin,
  output logic                Yin,
  output logic                Zin,
  output logic                LOin,
  output logic                HIin,
  output logic                IncPC,
  output logic                Read,
  output logic [NREG-1:0]     Rout,
  output logic [NREG-1:0]     Rin,
  output logic [OPCODE_W-1:0] operation,
  output logic                Done,
  output logic                Halted,
  output logic                Fault,
  output logic [3:0]          state_dbg
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALTED, S_FAULT
  } state_t;

  localparam int CW = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [OPCODE_W-1:0] OP_MUL  = OPCODE_W'(5'b01111);
  localparam logic [OPCODE_W-1:0] OP_DIV  = OPCODE_W'(5'b10000);
  localparam logic [OPCODE_W-1:0] OP_HALT = OPCODE_W'(5'b11011);

  state_t            state, state_nxt;
  logic [CW-1:0]     wait_cnt;
  logic              start;
  logic              after_done_run;

  // Instruction fields; IR is stable from T3 onward
  logic [OPCODE_W-1:0] op;
  logic [3:0]          ra, rb, rc;
  logic                is_alu, is_muldiv, is_exec, is_halt;
  logic                unused_ir;

  assign op        = IR[31:32-OPCODE_W];
  assign ra        = IR[26:23];
  assign rb        = IR[22:19];
  assign rc        = IR[18:15];
  assign unused_ir = ^IR[14:0];
  assign is_alu    = (op < OP_MUL);
  assign is_muldiv = (op == OP_MUL) || (op == OP_DIV);
  assign is_exec   = is_alu || is_muldiv;
  assign is_halt   = (op == OP_HALT);
  assign state_dbg = state;

`ifdef SINGLE_STEP_EN
  logic run_q;

  // Run history for rising-edge detection
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) run_q <= 1'b0;
    else          run_q <= Run;
  end

  assign start          = Run & ~run_q;
  assign after_done_run = 1'b0;
`else
  assign start          = Run;
  assign after_done_run = Run;
`endif

  // State register and memory wait counter (clears on T1 entry, saturates)
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state != S_T1 && state_nxt == S_T1)
        wait_cnt <= '0;
      else if (state == S_T1 && !Mem_ready && wait_cnt != CW'(MEM_WAIT_MAX))
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_T0;
      S_T0:     state_nxt = S_T1;
      S_T1: begin
        if (Mem_ready)                              state_nxt = S_T2;
        else if (wait_cnt == CW'(MEM_WAIT_MAX - 1)) state_nxt = S_FAULT;
      end
      S_T2:     state_nxt = S_T3;
      S_T3: begin
        if (is_exec)      state_nxt = S_T4;
        else if (is_halt) state_nxt = S_HALTED;
        else              state_nxt = S_FAULT;
      end
      S_T4:     state_nxt = S_T5;
      S_T5: begin
        if (is_muldiv)           state_nxt = S_T6;
        else if (after_done_run) state_nxt = S_T0;
        else                     state_nxt = S_IDLE;
      end
      S_T6:     state_nxt = after_done_run ? S_T0 : S_IDLE;
      S_HALTED: state_nxt = S_HALTED;
      S_FAULT:  state_nxt = S_FAULT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Moore output decode
  always_comb begin
    PCout = 1'b0; ZLowout = 1'b0; ZHighout = 1'b0; MDRout = 1'b0;
    MARin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0;
    Yin = 1'b0; Zin = 1'b0; LOin = 1'b0; HIin = 1'b0;
    IncPC = 1'b0; Read = 1'b0;
    Rout = '0; Rin = '0; operation = '0;
    Done = 1'b0; Halted = 1'b0; Fault = 1'b0;
    case (state)
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
      end
      S_T1: begin
        ZLowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
      end
      S_T3: begin
        if (is_exec) begin
          Rout = NREG'(1) << rb;
          Yin  = 1'b1;
        end
      end
      S_T4: begin
        Rout      = NREG'(1) << rc;
        Zin       = 1'b1;
        operation = op;
      end
      S_T5: begin
        ZLowout = 1'b1;
        if (is_muldiv) begin
          LOin = 1'b1;
        end else begin
          Rin  = NREG'(1) << ra;
          Done = 1'b1;
        end
      end
      S_T6: begin
        ZHighout = 1'b1; HIin = 1'b1; Done = 1'b1;
      end
      S_HALTED: Halted = 1'b1;
      S_FAULT:  Fault  = 1'b1;
      default: ;
    endcase
  end

  // At most one source drives the bus; GPR load is one-hot or zero
  a_one_bus_driver: assert property (@(posedge Clock) disable iff (!Reset_n)
    $onehot0({PCout, ZLowout, ZHighout, MDRout, Rout}));
  a_rin_onehot: assert property (@(posedge Clock) disable iff (!Reset_n)
    $onehot0(Rin));

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed instructions, expected strobe vectors
// pushed per cycle into a queue, popped by a monitor whenever the DUT shows
// activity (any strobe, or a rising Halted/Fault).
module tb_control_sequencer;
  localparam int W = 54;

  localparam logic [13:0] PCOUT = 14'h2000, ZLOW  = 14'h1000, ZHIGH  = 14'h0800,
                          MDROUT= 14'h0400, MARIN = 14'h0200, PCIN   = 14'h0100,
                          MDRIN = 14'h0080, IRIN  = 14'h0040, YIN    = 14'h0020,
                          ZIN   = 14'h0010, LOIN  = 14'h0008, HIIN   = 14'h0004,
                          INCPC = 14'h0002, READ  = 14'h0001;

  // Clock / reset
  logic Clock = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clock = ~Clock;

  logic        Run = 1'b0, Mem_ready = 1'b0;
  logic [31:0] IR = '0;
  logic PCout, ZLowout, ZHighout, MDRout, MARin, PCin, MDRin, IRin;
  logic Yin, Zin, LOin, HIin, IncPC, Read, Done, Halted, Fault;
  logic [15:0] Rout, Rin;
  logic [4:0]  operation;
  logic [3:0]  state_dbg;

  control_sequencer dut (
    .Clock(Clock), .Reset_n(Reset_n), .Run(Run), .Mem_ready(Mem_ready), .IR(IR),
    .PCout(PCout), .ZLowout(ZLowout), .ZHighout(ZHighout), .MDRout(MDRout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .LOin(LOin), .HIin(HIin), .IncPC(IncPC), .Read(Read), .Rout(Rout), .Rin(Rin),
    .operation(operation), .Done(Done), .Halted(Halted), .Fault(Fault),
    .state_dbg(state_dbg)
  );

  logic [W-1:0] act_vec;
  assign act_vec = {PCout, ZLowout, ZHighout, MDRout, MARin, PCin, MDRin, IRin,
                    Yin, Zin, LOin, HIin, IncPC, Read, Rout, Rin, operation,
                    Done, Halted, Fault};

  // Scoreboard state
  logic [W-1:0] exp_q[$];
  int           lat_q[$];
  int           n_cmp = 0, n_fail = 0;
  int           cyc = 0, t0_cyc = 0;
  logic         prev_h = 1'b0, prev_f = 1'b0;

  function automatic logic [W-1:0] mk(input logic [13:0] s, input logic [15:0] ro,
                                      input logic [15:0] ri, input logic [4:0] op,
                                      input logic d, input logic h, input logic f);
    return {s, ro, ri, op, d, h, f};
  endfunction

  task automatic check_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: pop and compare whenever the DUT presents activity
  always @(negedge Clock) begin
    logic active;
    cyc++;
    active = ((act_vec >> 2) != '0) || (Halted && !prev_h) || (Fault && !prev_f);
    if (active) begin
      if (PCout) t0_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_output at cycle %0d: got %h expected no activity", cyc, act_vec);
      end else begin
        check_vec("strobe_vector", act_vec, exp_q.pop_front());
      end
      if (Done) begin
        if (lat_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_done at cycle %0d: got Done=1 expected 0", cyc);
        end else begin
          check_int("latency", cyc - t0_cyc + 1, lat_q.pop_front());
        end
      end
    end
    prev_h = Halted;
    prev_f = Fault;
  end

  // Expected-sequence builders
  task automatic push_fetch(input int stall);
    exp_q.push_back(mk(PCOUT | MARIN | INCPC | ZIN, '0, '0, '0, 0, 0, 0));
    for (int i = 0; i <= stall; i++)
      exp_q.push_back(mk(ZLOW | PCIN | READ | MDRIN, '0, '0, '0, 0, 0, 0));
    exp_q.push_back(mk(MDROUT | IRIN, '0, '0, '0, 0, 0, 0));
  endtask

  task automatic push_t3_t4(input logic [15:0] rb_oh, input logic [15:0] rc_oh, input logic [4:0] op);
    exp_q.push_back(mk(YIN, rb_oh, '0, '0, 0, 0, 0));
    exp_q.push_back(mk(ZIN, rc_oh, '0, op, 0, 0, 0));
  endtask

  task automatic push_alu(input int stall, input logic [15:0] rb_oh, input logic [15:0] rc_oh,
                          input logic [15:0] ra_oh, input logic [4:0] op, input int lat);
    push_fetch(stall);
    push_t3_t4(rb_oh, rc_oh, op);
    exp_q.push_back(mk(ZLOW, '0, ra_oh, '0, 1, 0, 0));
    lat_q.push_back(lat);
  endtask

  task automatic push_muldiv(input logic [15:0] rb_oh, input logic [15:0] rc_oh, input logic [4:0] op);
    push_fetch(0);
    push_t3_t4(rb_oh, rc_oh, op);
    exp_q.push_back(mk(ZLOW | LOIN, '0, '0, '0, 0, 0, 0));
    exp_q.push_back(mk(ZHIGH | HIIN, '0, '0, '0, 1, 0, 0));
    lat_q.push_back(7);
  endtask

  // Driver tasks
  task automatic do_reset();
    @(negedge Clock);
    Reset_n = 1'b0; Run = 1'b0; Mem_ready = 1'b0; IR = '0;
    repeat (2) @(posedge Clock);
    #1 Reset_n = 1'b1;
  endtask

  // Pulse Run for one instruction; Mem_ready rises after 'stall' T1 cycles
  task automatic issue(input logic [31:0] ir, input int stall);
    @(posedge Clock); #1; IR = ir; Run = 1'b1;
    @(posedge Clock); #1; Run = 1'b0; Mem_ready = 1'b0;
    @(posedge Clock); #1;
    repeat (stall) begin @(posedge Clock); #1; end
    Mem_ready = 1'b1;
    @(posedge Clock); #1; Mem_ready = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge Clock);
      k++;
    end
    #1;
    check_int(name, exp_q.size(), 0);
    exp_q.delete();
    repeat (4) @(posedge Clock);
    check_int({name, "_lat_left"}, lat_q.size(), 0);
    lat_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout at cycle %0d: got no finish expected finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge Clock);
    #1;
    check_vec("reset_outputs", act_vec, '0);
    check_int("reset_state", state_dbg, 0);
    Reset_n = 1'b1;

    // ALU op 00101, Ra=4 Rb=5 Rc=7, no memory stall
    push_alu(0, 16'h0020, 16'h0080, 16'h0010, 5'b00101, 6);
    issue(32'h2A2B8000, 0);
    wait_drain("alu_basic", 40);

    // ALU op 00000, Ra=15 Rb=0 Rc=1, Mem_ready after 3 stall cycles
    push_alu(3, 16'h0001, 16'h0002, 16'h8000, 5'b00000, 9);
    issue(32'h07808000, 3);
    wait_drain("alu_stall3", 40);

    // MUL Rb=2 Rc=3
    push_muldiv(16'h0004, 16'h0008, 5'b01111);
    issue(32'h78918000, 0);
    wait_drain("mul", 40);

    // DIV Rb=14 Rc=0
    push_muldiv(16'h4000, 16'h0001, 5'b10000);
    issue(32'h84F00000, 0);
    wait_drain("div", 40);

    // Reset asserted mid-T4 clears every strobe immediately
    push_fetch(0);
    push_t3_t4(16'h0004, 16'h0008, 5'b01111);
    issue(32'h78918000, 0);
    @(posedge Clock);
    @(posedge Clock);
    #7;
    Reset_n = 1'b0;
    #1;
    check_vec("midT4_reset_outputs", act_vec, '0);
    check_int("midT4_reset_state", state_dbg, 0);
    check_int("midT4_reset_pending", exp_q.size(), 0);
    exp_q.delete();
    @(negedge Clock);
    Reset_n = 1'b1;
    repeat (4) @(posedge Clock);

`ifdef SINGLE_STEP_EN
    // Run held high: exactly one instruction, then a Run toggle starts another
    push_alu(0, 16'h0020, 16'h0080, 16'h0010, 5'b00101, 6);
    @(posedge Clock); #1; IR = 32'h2A2B8000; Run = 1'b1; Mem_ready = 1'b1;
    repeat (20) @(posedge Clock);
    wait_drain("single_step_1", 40);
    #1 Run = 1'b0;
    @(posedge Clock);
    push_alu(0, 16'h0020, 16'h0080, 16'h0010, 5'b00101, 6);
    #1 Run = 1'b1;
    repeat (20) @(posedge Clock);
    wait_drain("single_step_2", 40);
    #1 Run = 1'b0; Mem_ready = 1'b0;
`else
    // Run held over two instructions: back to back, then idle
    push_alu(0, 16'h0020, 16'h0080, 16'h0010, 5'b00101, 6);
    push_alu(0, 16'h0020, 16'h0080, 16'h0010, 5'b00101, 6);
    @(posedge Clock); #1; IR = 32'h2A2B8000; Run = 1'b1; Mem_ready = 1'b1;
    repeat (7) @(posedge Clock);
    #1 Run = 1'b0;
    wait_drain("back_to_back", 60);
    Mem_ready = 1'b0;
`endif

    // HALT: Halted rises, no Done, sticky
    push_fetch(0);
    exp_q.push_back(mk('0, '0, '0, '0, 0, 1, 0));
    issue(32'hD8000000, 0);
    wait_drain("halt", 40);
    check_int("halt_sticky", Halted, 1);
    do_reset();
    #1 check_int("halt_cleared", Halted, 0);

    // Illegal opcode 11111 -> Fault
    push_fetch(0);
    exp_q.push_back(mk('0, '0, '0, '0, 0, 0, 1));
    issue(32'hF8000000, 0);
    wait_drain("illegal_op", 40);
    do_reset();

    // Memory never ready: 15 stalled T1 cycles then Fault with Read low
    push_fetch(14);
    void'(exp_q.pop_back());  // no T2 after a timeout
    exp_q.push_back(mk('0, '0, '0, '0, 0, 0, 1));
    issue(32'h2A2B8000, 20);
    wait_drain("mem_timeout", 60);
    check_int("timeout_fault_level", Fault, 1);
    check_int("timeout_read_low", Read, 0);
    do_reset();
    #1 check_int("fault_cleared", Fault, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
